// File: rtl/instruction_fetch.sv
// Instruction fetch unit: 11-bit PC into a combinational program ROM, 14-bit IR,
// an 8-deep circular return stack for CALL/RET, and an INIT/RUN/SLEEP controller.
module instruction_fetch (
  input  logic        clk,
  input  logic        rst_n,
  output logic [10:0] Rom_addr_out,
  input  logic [13:0] Rom_data_in,
  input  logic        stall,
  input  logic        load_pc,
  input  logic [10:0] load_addr,
  input  logic        call,
  input  logic        ret,
  input  logic        sleep,
  input  logic        wake,
  output logic [13:0] ir_out,
  output logic        ir_valid,
  output logic [10:0] pc_out,
  output logic        stack_overflow,
  output logic        stack_underflow,
  output logic [1:0]  dbg_state_o,
  output logic [3:0]  dbg_count_o
);

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_SLEEP = 2'd2;

  // Handshake: none; stall is a level hold, redirect requests are sampled
  // once per non-stalled RUN cycle with priority ret > call > load_pc > sleep.

  logic [1:0]  state_q, state_d;
  logic [10:0] pc_q, pc_d;
  logic [13:0] ir_q, ir_d;
  logic        valid_q, valid_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic        push;
  logic [2:0]  ptr_m1;
  logic [10:0] stack_q [8];

  assign ptr_m1 = ptr_q - 3'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    case (state_q)
      S_INIT: state_d = S_RUN;
      S_RUN: begin
        if (!stall) begin
          if (ret) begin
            // An empty pop still follows the wrapped pointer; only the flag marks it.
            pc_d    = stack_q[ptr_m1];
            valid_d = 1'b0;
            ptr_d   = ptr_m1;
            if (cnt_q == 4'd0) unf_d = 1'b1;
            else               cnt_d = cnt_q - 4'd1;
          end else if (call) begin
            push    = 1'b1;
            pc_d    = load_addr;
            valid_d = 1'b0;
            ptr_d   = ptr_q + 3'd1;
            if (cnt_q == 4'd8) ovf_d = 1'b1;
            else               cnt_d = cnt_q + 4'd1;
          end else if (load_pc) begin
            pc_d    = load_addr;
            valid_d = 1'b0;
          end else if (sleep) begin
            state_d = S_SLEEP;
            valid_d = 1'b0;
          end else begin
            ir_d    = Rom_data_in;
            valid_d = 1'b1;
            pc_d    = pc_q + 11'd1;
          end
        end
      end
      S_SLEEP: begin
        valid_d = 1'b0;
        if (wake) state_d = S_RUN;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      pc_q    <= 11'h000;
      ir_q    <= 14'h0000;
      valid_q <= 1'b0;
      ptr_q   <= 3'd0;
      cnt_q   <= 4'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) stack_q[ptr_q] <= pc_q;
  end

  assign Rom_addr_out    = pc_q;
  assign pc_out          = pc_q;
  assign ir_out          = ir_q;
  assign ir_valid        = valid_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;
  assign dbg_state_o     = state_q;
  assign dbg_count_o     = cnt_q;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 Rom_addr_out  output  11  program ROM address; combinationally equals PC.
REQ-004 Rom_data_in  input  14  program ROM word, valid in the same cycle as Rom_addr_out (combinational ROM).
REQ-005 stall  input  1  hold PC, IR and ir_valid.
REQ-006 load_pc  input  1  jump request (GOTO), target on load_addr.
REQ-007 load_addr  input  11  jump/call target.
REQ-008 call  input  1  push return address, jump to load_addr.
REQ-009 ret  input  1  pop return address into PC.
REQ-010 sleep  input  1  enter SLEEP state.
REQ-011 wake  input  1  leave SLEEP state.
REQ-012 ir_out  output  14  instruction register.
REQ-013 ir_valid  output  1  ir_out holds a correct-path instruction.
REQ-014 pc_out  output  11  current PC, equal to Rom_addr_out.
REQ-015 stack_overflow  output  1  sticky push-when-full flag.
REQ-016 stack_underflow  output  1  sticky pop-when-empty flag.

Function
REQ-017 FSM states: S_INIT, S_RUN, S_SLEEP; S_INIT lasts exactly one cycle after reset release, then S_RUN.
REQ-018 S_INIT: no fetch; ir_valid=0; PC=0x000; all control inputs ignored.
REQ-019 S_RUN, stall=0, no redirect: IR<=Rom_data_in, ir_valid<=1, PC<=PC+1 modulo 2^11 (0x7FF wraps to 0x000).
REQ-020 S_RUN, stall=1: PC, IR, ir_valid, stack and flags unchanged; load_pc/call/ret/sleep ignored.
REQ-021 Redirect priority when stall=0: ret > call > load_pc; only the highest-priority asserted request acts.
REQ-022 Any redirect: PC<=target, ir_valid<=0 (wrong-path word discarded), IR unchanged; the next cycle fetches from the target.
REQ-023 load_pc target = load_addr.
REQ-024 call: push current PC (address following the CALL in ir_out), target = load_addr.
REQ-025 ret: target = top of stack, then pop.
REQ-026 Stack: 8 entries x 11 bits, circular, with a 3-bit pointer and a 0..8 occupancy count.
REQ-027 Push when count=8: overwrite oldest entry (pointer wraps), set stack_overflow, count stays 8.
REQ-028 Pop when count=0: still redirect to the entry under the wrapped pointer, set stack_underflow, count stays 0.
REQ-029 stack_overflow and stack_underflow clear only on reset.
REQ-030 S_RUN, stall=0, sleep=1, no redirect: go to S_SLEEP, ir_valid<=0, PC held; redirect requests take precedence over sleep.
REQ-031 S_SLEEP: PC, IR and stack held, ir_valid=0; wake=1 returns to S_RUN next cycle, and fetch resumes at the held PC.
REQ-032 No combinational path from any input to any output other than Rom_addr_out/pc_out, which follow PC.

Reset
REQ-033 rst_n=0 immediately forces: PC=0x000, ir_out=0x0000, ir_valid=0, stack count=0, pointer=0, both flags=0, state=S_INIT; this includes assertion in mid-fetch or mid-SLEEP.
REQ-034 Stack entry contents need not be reset.

Verification
REQ-035 ROM 0x000..0x006 = 3044,3E01,3802,39FE,3C47,3A55,3AAA; reset release -> cycle 1: ir_valid=0; cycles 2..8: ir_out is each word in order with ir_valid=1, pc_out 0x001..0x007.
REQ-036 load_pc=1, load_addr=0x004 at PC=0x002 -> next cycle ir_valid=0, pc_out=0x004; following cycle ir_out=3C47.
REQ-037 call to 0x005 at PC=0x003, then ret two cycles later -> pc_out 0x005, 0x006, then 0x003; stack count returns to 0; no flags set.
REQ-038 9 consecutive calls -> stack_overflow=1 after the 9th; 9 rets then return the pushed addresses of calls 9..2, then call 9's address again; stack_underflow=1 after the 9th ret.
REQ-039 stall=1 for 3 cycles with load_pc asserted -> PC, ir_out and ir_valid are frozen and the jump is not taken; sleep then wake -> ir_valid=0 during SLEEP and fetch resumes at the held PC.
REQ-040 PC=0x7FF, no redirect -> next pc_out=0x000; rst_n pulsed low in SLEEP -> outputs at reset values asynchronously, then S_INIT.
